fir_decim_buffer: RTL and testbench

Output stage placed directly downstream of the 9-tap symmetric FIR. It samples the FIR's 16-bit signed output `y` on every qualified sample strobe and keeps every DECIM-th sample. Retained samples go into a small first-word-fall-through FIFO, which presents them to the consumer over a valid/ready handshake. A FIFO overflow drops the sample and raises a sticky flag.

---
 rtl/fir_pkg.sv | 9 +
 rtl/fir_sample_fifo.sv | 69 ++++++
 rtl/fir_decim_buffer.sv | 97 +++++++++
 tb/tb_fir_decim_buffer.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/fir_pkg.sv
// Shared FIR datapath types: sample format and drop-counter width.
package fir_pkg;

  localparam int SAMPLE_W  = 16;
  localparam int DROPCNT_W = 16;

  typedef logic signed [SAMPLE_W-1:0] sample_t;

endpackage

// File: rtl/fir_sample_fifo.sv
// First-word-fall-through sample FIFO; full/empty derived from level.
module fir_sample_fifo
  import fir_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       push_i,
  input  logic                       pop_i,
  input  sample_t                    wdata_i,
  output sample_t                    rdata_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH+1)-1:0] level_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = $clog2(DEPTH+1);

  sample_t mem [DEPTH];

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0] level_q, level_d;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end else begin
      if (push_i) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop_i)  rd_ptr_d = rd_ptr_q + 1'b1;
      unique case ({push_i, pop_i})
        2'b10:   level_d = level_q + 1'b1;
        2'b01:   level_d = level_q - 1'b1;
        default: level_d = level_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // When full, wr_ptr equals rd_ptr: a same-cycle pop still reads the old head.
  always_ff @(posedge clk) begin
    if (push_i && !flush) mem[wr_ptr_q] <= wdata_i;
  end

  assign rdata_o = mem[rd_ptr_q];
  assign full_o  = (level_q == LVL_W'(DEPTH));
  assign empty_o = (level_q == '0);
  assign level_o = level_q;

endmodule

// File: rtl/fir_decim_buffer.sv
// FIR output decimator feeding a FWFT FIFO with sticky overflow.
// Optional drop counter enabled by FIR_DECIM_DROPCNT_EN.
module fir_decim_buffer
  import fir_pkg::*;
#(
  parameter int DECIM = 4,
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  sample_t                    in_data,
  input  logic                       in_en,
  output sample_t                    out_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [$clog2(DEPTH+1)-1:0] level,
  output logic                       overflow
`ifdef FIR_DECIM_DROPCNT_EN
  ,
  output logic [DROPCNT_W-1:0]       drop_count
`endif
);

  localparam int PH_W = (DECIM > 1) ? $clog2(DECIM) : 1;
  localparam logic [PH_W-1:0] PH_LAST = PH_W'(DECIM - 1);

  logic [PH_W-1:0] ph_q, ph_d;
  logic            ovf_q, ovf_d;
  logic            full, empty;
  logic            dec, push, pop, drop;

  assign dec  = in_en && (ph_q == PH_LAST);
  assign pop  = !empty && out_ready;
  assign push = dec && (!full || pop);
  assign drop = dec && full && !pop;

  always_comb begin
    ph_d  = ph_q;
    ovf_d = ovf_q;
    if (flush) begin
      ph_d  = '0;
      ovf_d = 1'b0;
    end else begin
      if (in_en) ph_d = (ph_q == PH_LAST) ? '0 : ph_q + 1'b1;
      if (drop)  ovf_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ph_q  <= '0;
      ovf_q <= 1'b0;
    end else begin
      ph_q  <= ph_d;
      ovf_q <= ovf_d;
    end
  end

`ifdef FIR_DECIM_DROPCNT_EN
  logic [DROPCNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (flush)
      cnt_d = '0;
    else if (drop && cnt_q != '1)
      cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign drop_count = cnt_q;
`endif

  fir_sample_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk    (clk),
    .rst    (rst),
    .flush  (flush),
    .push_i (push),
    .pop_i  (pop),
    .wdata_i(in_data),
    .rdata_o(out_data),
    .full_o (full),
    .empty_o(empty),
    .level_o(level)
  );

  assign out_valid = !empty;
  assign overflow  = ovf_q;

endmodule

// File: tb/tb_fir_decim_buffer.sv
// Directed bench: DECIM=4 and DECIM=1 instances, DEPTH=8.
module tb_fir_decim_buffer;
  import fir_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  logic       rst4, flush4, en4, rdy4, val4, ovf4;
  sample_t    din4, dout4;
  logic [3:0] lvl4;

  logic       rst1, flush1, en1, rdy1, val1, ovf1;
  sample_t    din1, dout1;
  logic [3:0] lvl1;

`ifdef FIR_DECIM_DROPCNT_EN
  logic [15:0] dc4, dc1;
`endif

  fir_decim_buffer #(.DECIM(4), .DEPTH(8)) u4 (
    .clk(clk), .rst(rst4), .flush(flush4),
    .in_data(din4), .in_en(en4),
    .out_data(dout4), .out_valid(val4), .out_ready(rdy4),
    .level(lvl4), .overflow(ovf4)
`ifdef FIR_DECIM_DROPCNT_EN
    , .drop_count(dc4)
`endif
  );

  fir_decim_buffer #(.DECIM(1), .DEPTH(8)) u1 (
    .clk(clk), .rst(rst1), .flush(flush1),
    .in_data(din1), .in_en(en1),
    .out_data(dout1), .out_valid(val1), .out_ready(rdy1),
    .level(lvl1), .overflow(ovf1)
`ifdef FIR_DECIM_DROPCNT_EN
    , .drop_count(dc1)
`endif
  );

  task automatic chk(input string tag, input logic [15:0] obs,
                     input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst4 = 1'b1; flush4 = 1'b0; en4 = 1'b0; rdy4 = 1'b0; din4 = '0;
    rst1 = 1'b1; flush1 = 1'b0; en1 = 1'b0; rdy1 = 1'b0; din1 = '0;
    tick();
    chk("rst_valid", 16'(val4), 16'd0);
    chk("rst_level", 16'(lvl4), 16'd0);
    chk("rst_ovf", 16'(ovf4), 16'd0);
`ifdef FIR_DECIM_DROPCNT_EN
    chk("rst_dcnt", dc4, 16'd0);
`endif
    tick();
    rst4 = 1'b0; rst1 = 1'b0;
    tick();

    // DECIM=4: strobes 1..8, keep 4 and 8
    rdy4 = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      en4 = 1'b1; din4 = sample_t'(i);
      tick();
      chk($sformatf("d4_valid_%0d", i), 16'(val4),
          16'((i % 4) == 0));
      if ((i % 4) == 0) begin
        chk($sformatf("d4_data_%0d", i), dout4, 16'(i));
        chk($sformatf("d4_lvl_%0d", i), 16'(lvl4), 16'd1);
      end
    end
    en4 = 1'b0;
    tick();
    chk("d4_lvl_end", 16'(lvl4), 16'd0);

    // DECIM=1: extremes, continuous strobe
    rdy1 = 1'b1; en1 = 1'b1;
    din1 = 16'sh8000; tick();
    chk("d1_min", dout1, 16'h8000);
    chk("d1_min_lvl", 16'(lvl1), 16'd1);
    din1 = 16'sh7FFF; tick();
    chk("d1_max", dout1, 16'h7FFF);
    chk("d1_max_lvl", 16'(lvl1), 16'd1);
    din1 = -16'sd1; tick();
    chk("d1_m1", dout1, 16'hFFFF);
    chk("d1_m1_lvl", 16'(lvl1), 16'd1);
    en1 = 1'b0; tick();
    chk("d1_empty", 16'(val1), 16'd0);

    // overflow: 10 strobes into depth 8, consumer stalled
    rdy1 = 1'b0;
    for (int i = 0; i < 10; i++) begin
      en1 = 1'b1; din1 = sample_t'(100 + i);
      tick();
      if (i == 7) begin
        chk("ovf_lvl8", 16'(lvl1), 16'd8);
        chk("ovf_pre", 16'(ovf1), 16'd0);
      end
    end
    en1 = 1'b0;
    chk("ovf_lvl", 16'(lvl1), 16'd8);
    chk("ovf_flag", 16'(ovf1), 16'd1);
`ifdef FIR_DECIM_DROPCNT_EN
    chk("ovf_dcnt", dc1, 16'd2);
`endif
    tick();
    chk("ovf_hold", dout1, 16'd100);
    rdy1 = 1'b1;
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("drain_%0d", i), dout1, 16'(100 + i));
      tick();
    end
    chk("drain_lvl", 16'(lvl1), 16'd0);
    chk("drain_ovf", 16'(ovf1), 16'd1);

    // full with simultaneous push and pop
    rdy1 = 1'b0; flush1 = 1'b1; tick();
    flush1 = 1'b0;
    chk("fl_ovf", 16'(ovf1), 16'd0);
`ifdef FIR_DECIM_DROPCNT_EN
    chk("fl_dcnt", dc1, 16'd0);
`endif
    for (int i = 0; i < 8; i++) begin
      en1 = 1'b1; din1 = sample_t'(200 + i); tick();
    end
    din1 = 16'sd300; rdy1 = 1'b1; tick();
    en1 = 1'b0;
    chk("pp_lvl", 16'(lvl1), 16'd8);
    chk("pp_ovf", 16'(ovf1), 16'd0);
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("pp_drain_%0d", i), dout1,
          (i < 7) ? 16'(201 + i) : 16'd300);
      tick();
    end
    chk("pp_lvl_end", 16'(lvl1), 16'd0);

    // flush on a decimation strobe with 3 held
    rdy4 = 1'b0;
    for (int i = 1; i <= 15; i++) begin
      en4 = 1'b1; din4 = sample_t'(10 + i); tick();
    end
    chk("fd_lvl3", 16'(lvl4), 16'd3);
    din4 = 16'sd999; flush4 = 1'b1; tick();
    flush4 = 1'b0;
    chk("fd_lvl", 16'(lvl4), 16'd0);
    chk("fd_valid", 16'(val4), 16'd0);
    chk("fd_ovf", 16'(ovf4), 16'd0);
    for (int i = 1; i <= 4; i++) begin
      din4 = sample_t'(50 + i); tick();
      if (i == 3) chk("fd_3rd", 16'(val4), 16'd0);
    end
    chk("fd_4th_v", 16'(val4), 16'd1);
    chk("fd_4th_d", dout4, 16'd54);

    // async reset mid-cycle at level 5 with partial phase
    for (int i = 0; i < 18; i++) begin
      din4 = sample_t'(i); tick();
    end
    en4 = 1'b0;
    chk("ar_lvl5", 16'(lvl4), 16'd5);
    #3 rst4 = 1'b1;
    #1;
    chk("ar_lvl", 16'(lvl4), 16'd0);
    chk("ar_valid", 16'(val4), 16'd0);
    #1 rst4 = 1'b0;
    tick();
    for (int i = 1; i <= 4; i++) begin
      en4 = 1'b1; din4 = sample_t'(70 + i); tick();
      if (i == 3) chk("ar_ph_3", 16'(val4), 16'd0);
    end
    en4 = 1'b0;
    chk("ar_ph_4", dout4, 16'd74);
    chk("ar_ph_lvl", 16'(lvl4), 16'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
